// File: rtl/defs.sv
// Shared definitions for the integer register file: sizes, index/word types,
// the CLEAR/RUN state encoding and a small write-qualification helper.
// Latency: n/a (types only). Backpressure: n/a.
package defs;

  // Architectural sizes.
  localparam int NUM_REGS = 32;
  localparam int XLEN     = 32;
  localparam int IDX_W    = $clog2(NUM_REGS);

  typedef logic [XLEN-1:0]  word_t;
  typedef logic [IDX_W-1:0] idx_t;

  // Highest architectural index; the clear sequence ends on it.
  localparam idx_t LAST_IDX  = idx_t'(NUM_REGS - 1);
  // First index with storage; x0 is hardwired to zero.
  localparam idx_t FIRST_IDX = idx_t'(1);

  // Single state encoding for the whole block.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

  // A write request only targets storage when it is enabled and not aimed at x0.
  function automatic logic live_write(input logic en, input idx_t idx);
    return en && (idx != '0);
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port with write-through bypass and x0 / clear blanking.
// Latency: zero cycles, pure combinational mux.
// Backpressure: none; the caller blanks the port while a clear is running.
//
// Ports:
//   idx_i       read index
//   arr_data_i  stored value at idx_i (don't-care when idx_i == 0)
//   blank_i     force zero (clear sequence in progress)
//   byp_en_i    a qualified write to a non-zero register is happening this cycle
//   byp_reg_i   destination index of that write
//   byp_data_i  data of that write
//   data_o      read result
module rf_read_port
  import defs::*;
(
  input  logic [IDX_W-1:0] idx_i,
  input  logic [XLEN-1:0]  arr_data_i,
  input  logic             blank_i,
  input  logic             byp_en_i,
  input  logic [IDX_W-1:0] byp_reg_i,
  input  logic [XLEN-1:0]  byp_data_i,
  output logic [XLEN-1:0]  data_o
);

  always_comb begin
    data_o = arr_data_i;
    if (blank_i || (idx_i == '0)) begin
      // x0 has no storage and never bypasses, even on a write aimed at it.
      data_o = '0;
    end else if (byp_en_i && (byp_reg_i == idx_i)) begin
      // Same-cycle write wins over the stale stored value.
      data_o = byp_data_i;
    end
  end

endmodule

// File: rtl/reg_file.sv
// 31 x 32-bit integer register file (x1..x31), two read ports, one write port.
// Latency: reads combinational with write-through bypass; writes land on the next edge.
// Backpressure: busy_o is high for 31 cycles after reset while registers are zeroed;
//   writes are ignored and reads return zero during that window.
//
// Ports:
//   clk_i         clock, all state on the rising edge
//   rst_i         synchronous active-high reset
//   rf_wr_en_i    write enable (already qualified by the writeback stage)
//   rf_wr_reg_i   write index; index 0 is dropped
//   rf_wr_data_i  write data
//   rs1_i/rs2_i   read indices
//   rs1_data_oa   read data port 1 (combinational)
//   rs2_data_oa   read data port 2 (combinational)
//   busy_o        clear sequence running (registered, used as a stall request)
module reg_file
  import defs::*;
#(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rf_wr_en_i,
  input  logic [IDX_W-1:0] rf_wr_reg_i,
  input  logic [XLEN-1:0]  rf_wr_data_i,
  input  logic [IDX_W-1:0] rs1_i,
  input  logic [IDX_W-1:0] rs2_i,
  output logic [XLEN-1:0]  rs1_data_oa,
  output logic [XLEN-1:0]  rs2_data_oa,
  output logic             busy_o
);

  // --------------------------------------------------------------------------
  // Control state
  // --------------------------------------------------------------------------
  rf_state_t state_q, state_d;
  idx_t      cnt_q, cnt_d;

  // Array write port, shared by the clear sequence and normal writeback.
  logic  mem_we;
  idx_t  mem_waddr;
  word_t mem_wdata;

  logic  wr_live;
  logic  byp_en;

  assign wr_live = live_write(rf_wr_en_i, rf_wr_reg_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CLEAR_ON_RESET ? CLEAR : RUN;
      cnt_q   <= FIRST_IDX;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = rf_wr_reg_i;
    mem_wdata = rf_wr_data_i;
    case (state_q)
      CLEAR: begin
        // One register zeroed per cycle; external writes are locked out.
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + idx_t'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = RUN;
        end
      end
      RUN: begin
        mem_we = wr_live;
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = FIRST_IDX;
      end
    endcase
  end

  assign busy_o = (state_q == CLEAR);

  // --------------------------------------------------------------------------
  // Storage: no reset term so it can map onto plain flops or LUTRAM. The reset
  // edge itself never writes; a write presented during reset is discarded.
  // --------------------------------------------------------------------------
  word_t mem_q [FIRST_IDX:LAST_IDX];

  always_ff @(posedge clk_i) begin
    if (mem_we && !rst_i) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Read ports. Index 0 has no storage, so it is steered away from the array.
  // --------------------------------------------------------------------------
  word_t arr1, arr2;

  assign arr1   = (rs1_i == '0) ? '0 : mem_q[rs1_i];
  assign arr2   = (rs2_i == '0) ? '0 : mem_q[rs2_i];
  assign byp_en = wr_live && (state_q == RUN);

  rf_read_port u_rd1 (
    .idx_i      (rs1_i),
    .arr_data_i (arr1),
    .blank_i    (busy_o),
    .byp_en_i   (byp_en),
    .byp_reg_i  (rf_wr_reg_i),
    .byp_data_i (rf_wr_data_i),
    .data_o     (rs1_data_oa)
  );

  rf_read_port u_rd2 (
    .idx_i      (rs2_i),
    .arr_data_i (arr2),
    .blank_i    (busy_o),
    .byp_en_i   (byp_en),
    .byp_reg_i  (rf_wr_reg_i),
    .byp_data_i (rf_wr_data_i),
    .data_o     (rs2_data_oa)
  );

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: one instance clears on reset, one retains contents.
// Stimulus pushes expected outputs into a scoreboard; a negedge monitor pops and compares.
module tb_reg_file;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: CLEAR_ON_RESET = 1
  logic        rst_a, en_a;
  logic [4:0]  wr_a, rs1_a, rs2_a;
  logic [31:0] wd_a, r1_a, r2_a;
  logic        busy_a;
  // Instance B: CLEAR_ON_RESET = 0
  logic        rst_b, en_b;
  logic [4:0]  wr_b, rs1_b, rs2_b;
  logic [31:0] wd_b, r1_b, r2_b;
  logic        busy_b;

  reg_file #(.CLEAR_ON_RESET(1'b1)) dut (
    .clk_i(clk), .rst_i(rst_a), .rf_wr_en_i(en_a), .rf_wr_reg_i(wr_a),
    .rf_wr_data_i(wd_a), .rs1_i(rs1_a), .rs2_i(rs2_a),
    .rs1_data_oa(r1_a), .rs2_data_oa(r2_a), .busy_o(busy_a)
  );

  reg_file #(.CLEAR_ON_RESET(1'b0)) dut_nc (
    .clk_i(clk), .rst_i(rst_b), .rf_wr_en_i(en_b), .rf_wr_reg_i(wr_b),
    .rf_wr_data_i(wd_b), .rs1_i(rs1_b), .rs2_i(rs2_b),
    .rs1_data_oa(r1_b), .rs2_data_oa(r2_b), .busy_o(busy_b)
  );

  typedef struct {
    bit          nc;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        busy;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model: plain arrays plus "cycles of clearing still to go".
  logic [31:0] ma [32];
  logic [31:0] mb [32];
  int          clear_left = 0;

  function automatic logic [31:0] model_read(input bit nc, input logic [4:0] idx,
                                             input logic en, input logic [4:0] wr,
                                             input logic [31:0] wd);
    if (!nc && clear_left > 0) return 32'h0;
    if (idx == 5'd0) return 32'h0;
    if (en && wr == idx) return wd;
    return nc ? mb[idx] : ma[idx];
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so each scoreboard entry is checked mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.nc) begin
        cmp({e.tag, ".rs1"},  r1_b, e.r1);
        cmp({e.tag, ".rs2"},  r2_b, e.r2);
        cmp({e.tag, ".busy"}, {31'b0, busy_b}, {31'b0, e.busy});
      end else begin
        cmp({e.tag, ".rs1"},  r1_a, e.r1);
        cmp({e.tag, ".rs2"},  r2_a, e.r2);
        cmp({e.tag, ".busy"}, {31'b0, busy_a}, {31'b0, e.busy});
      end
    end
  end

  // One clock cycle: drive the selected instance, idle the other, predict, advance model.
  task automatic step(input bit nc, input logic rst, input logic en, input logic [4:0] wr,
                      input logic [31:0] wd, input logic [4:0] a, input logic [4:0] b,
                      input string tag, input bit chk);
    exp_t e;
    rst_a = nc ? 1'b0 : rst;  en_a = nc ? 1'b0 : en;
    wr_a  = wr; wd_a = wd; rs1_a = a; rs2_a = b;
    rst_b = nc ? rst : 1'b0;  en_b = nc ? en : 1'b0;
    wr_b  = wr; wd_b = wd; rs1_b = a; rs2_b = b;
    if (chk) begin
      e.nc   = nc;
      e.r1   = model_read(nc, a, en, wr, wd);
      e.r2   = model_read(nc, b, en, wr, wd);
      e.busy = nc ? 1'b0 : (clear_left > 0);
      e.tag  = tag;
      sb.push_back(e);
    end
    @(posedge clk);
    // Instance A edge effects
    if (rst_a) begin
      clear_left = 31;
    end else if (clear_left > 0) begin
      ma[32 - clear_left] = 32'h0;
      clear_left--;
    end else if (en_a && wr_a != 5'd0) begin
      ma[wr_a] = wd_a;
    end
    // Instance B edge effects: reset never clears or writes
    if (!rst_b && en_b && wr_b != 5'd0) mb[wr_b] = wd_b;
    #1;
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 32; i++) begin
      ma[i] = 32'h0;
      mb[i] = 32'h0;
    end
    rst_a = 1'b1; en_a = 1'b0; wr_a = '0; wd_a = '0; rs1_a = '0; rs2_a = '0;
    rst_b = 1'b0; en_b = 1'b0; wr_b = '0; wd_b = '0; rs1_b = '0; rs2_b = '0;

    // Power-up reset: state unknown before the first edge, so nothing is checked yet.
    step(0, 1, 0, 0, 0, 0, 0, "por", 0);
    step(0, 1, 0, 0, 0, 1, 2, "reset_state", 1);

    // Clear window: busy for 31 cycles, writes ignored, reads zero.
    for (int i = 0; i < 31; i++)
      step(0, 0, 1'($urandom_range(0, 1)), 5'($urandom), $urandom, 5'($urandom),
           5'($urandom), "clear_window", 1);
    for (int i = 1; i < 32; i++)
      step(0, 0, 0, 0, 0, 5'(i), 5'(32 - i), "cleared_read", 1);

    // Write then read back, x0 on the other port.
    step(0, 0, 1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, "wr_x5_bypass", 1);
    step(0, 0, 0, 0, 0, 5'd5, 5'd0, "rd_x5", 1);
    // Both ports bypass the same write.
    step(0, 0, 1, 5'd7, 32'h12345678, 5'd7, 5'd7, "bypass_both", 1);
    step(0, 0, 0, 0, 0, 5'd7, 5'd5, "rd_x7", 1);
    // x0 protection: no storage, no bypass.
    step(0, 0, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, "wr_x0", 1);
    step(0, 0, 0, 0, 0, 5'd0, 5'd7, "rd_x0", 1);

    // Random traffic with occasional resets (resets carry no write).
    for (int i = 0; i < 400; i++) begin
      logic r, en;
      logic [4:0] wr, a, b;
      r  = ($urandom_range(0, 59) == 0);
      en = r ? 1'b0 : 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      a  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      b  = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom);
      step(0, r, en, wr, $urandom, a, b, "random", 1);
    end
    guard = 0;
    while (clear_left > 0 && guard < 40) begin
      step(0, 0, 0, 0, 0, 0, 0, "drain", 1);
      guard++;
    end

    // Reset mid-clear: x3 holds data, clear restarts, late write to x3 is dropped.
    step(0, 0, 1, 5'd3, 32'hCAFEF00D, 5'd3, 5'd0, "pre_x3", 1);
    step(0, 1, 0, 0, 0, 5'd3, 5'd0, "rst1", 1);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0, 5'd3, 5'd0, "clear_a", 1);
    step(0, 1, 0, 0, 0, 5'd3, 5'd0, "rst_mid_clear", 1);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 5'd3, 5'd1, "clear_b", 1);
    step(0, 0, 1, 5'd3, 32'h0BADBEEF, 5'd3, 5'd3, "wr_x3_in_clear", 1);
    guard = 0;
    while (clear_left > 0 && guard < 40) begin
      step(0, 0, 0, 0, 0, 5'd3, 5'd31, "clear_c", 1);
      guard++;
    end
    step(0, 0, 0, 0, 0, 5'd3, 5'd31, "x3_after_clear", 1);

    // Retaining instance: no clear, contents survive reset, write on reset edge dropped.
    step(1, 1, 0, 0, 0, 0, 0, "nc_por", 0);
    step(1, 0, 1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd0, "nc_wr_x9", 1);
    step(1, 0, 0, 0, 0, 5'd9, 5'd9, "nc_rd_x9", 1);
    step(1, 1, 1, 5'd9, 32'h11111111, 5'd0, 5'd0, "nc_rst_wr", 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 5'd9, 5'd0, "nc_after_rst", 1);
    step(1, 0, 1, 5'd12, 32'h5A5A0000, 5'd12, 5'd9, "nc_wr_x12", 1);
    step(1, 1, 0, 0, 0, 5'd12, 5'd9, "nc_rst2", 1);
    step(1, 0, 0, 0, 0, 5'd12, 5'd9, "nc_rd_both", 1);

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
